// File: rtl/seg_disp_pkg.sv
// Shared constants, mode encodings and FSM state type for the scrolling
// seven-segment display block.
package seg_disp_pkg;

   localparam int SEG_W_MAX = 16;
   // Segments are active-low, so an unlit digit is all ones.
   localparam logic [SEG_W_MAX-1:0] SEG_BLANK = '1;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_ONCE   = 2'b01,
      MODE_CONT   = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHOW   = 2'b01,
      SCROLL = 2'b10
   } state_e;

   // The unused 2'b11 encoding falls back to static display.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      case (raw)
         2'b01:   return MODE_ONCE;
         2'b10:   return MODE_CONT;
         default: return MODE_STATIC;
      endcase
   endfunction

endpackage

// File: rtl/seg_scroll_display_if.sv
// Buffer-write, control and display signals of seg_scroll_display.
interface seg_scroll_display_if #(
   parameter int NUM_DIGITS = 5,
   parameter int MSG_DEPTH  = 16,
   parameter int SEG_W      = 7
);
   localparam int AW = $clog2(MSG_DEPTH);
   localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS);

   logic                        wr_en;
   logic [AW-1:0]               wr_addr;
   logic [SEG_W-1:0]            wr_data;
   logic [AW:0]                 msg_len;
   logic [1:0]                  mode;
   logic                        start;
   logic                        stop;
   logic [NUM_DIGITS*SEG_W-1:0] display_out;
   logic                        busy;
   logic                        done;
   logic [PW-1:0]               window_pos;

   modport master (
      output wr_en, wr_addr, wr_data, msg_len, mode, start, stop,
      input  display_out, busy, done, window_pos
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, msg_len, mode, start, stop,
      output display_out, busy, done, window_pos
   );

endinterface

// File: rtl/seg_tick_div.sv
// Scroll-step divider: counts 0..TICK_DIV-1 while enabled and pulses step
// on the wrap cycle; clear restarts the period from zero.
module seg_tick_div #(
   parameter int TICK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic step
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q;

   assign step = enable && !clear && (count_q == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= (count_q == LAST) ? '0 : count_q + CW'(1);
      end
   end

endmodule

// File: rtl/seg_scroll_display.sv
// Message buffer plus static / scroll-once / scroll-continuous window driver
// for a row of active-low seven-segment digits; all outputs are registered.
module seg_scroll_display
   import seg_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 5,
   parameter int MSG_DEPTH  = 16,
   parameter int SEG_W      = 7,
   parameter int TICK_DIV   = 25000000
) (
   input logic                 clk,
   input logic                 reset,
   seg_scroll_display_if.slave bus
);

   localparam int AW = $clog2(MSG_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS);
   localparam int IW = PW + 1;
   localparam int FW = NUM_DIGITS * SEG_W;
   localparam logic [SEG_W-1:0] BLANK = SEG_BLANK[SEG_W-1:0];

   logic [SEG_W-1:0] msg_buf [MSG_DEPTH];

   state_e        state_q;
   mode_e         mode_q;
   logic [LW-1:0] len_q;
   logic [PW-1:0] window_pos_q;
   logic          busy_q;
   logic          done_q;
   logic [FW-1:0] frame;
   logic [FW-1:0] display_p1;

   logic [LW-1:0] len_in;
   mode_e         mode_in;
   logic [IW-1:0] stream_len;
   logic          step;
   logic          at_last;
   logic          at_end;

   assign len_in     = (bus.msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : bus.msg_len;
   assign mode_in    = decode_mode(bus.mode);
   assign stream_len = IW'(len_q) + IW'(NUM_DIGITS);
   assign at_last    = (IW'(window_pos_q) == stream_len - IW'(1));
   assign at_end     = (IW'(window_pos_q) == IW'(len_q));

   seg_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (bus.start | bus.stop),
      .enable (state_q == SCROLL),
      .step   (step)
   );

   // Buffer contents carry no reset; writes are accepted in every state.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         msg_buf[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mode_q       <= MODE_STATIC;
         len_q        <= '0;
         window_pos_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else if (bus.start) begin
            len_q        <= len_in;
            mode_q       <= mode_in;
            window_pos_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= (mode_in == MODE_STATIC) ? SHOW : SCROLL;
         end else if (state_q == SCROLL && step) begin
            if (mode_q == MODE_ONCE && at_end) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else if (at_last) begin
               window_pos_q <= '0;
            end else begin
               window_pos_q <= window_pos_q + PW'(1);
            end
         end
      end
   end

   // Window lookup into the virtual stream: buffer entries, then NUM_DIGITS blanks.
   always_comb begin
      logic [IW-1:0] idx;
      frame = {NUM_DIGITS{BLANK}};
      idx   = '0;
      if (state_q != IDLE) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            idx = IW'(window_pos_q) + IW'(i);
            if (idx >= stream_len) begin
               idx = idx - stream_len;
            end
            if (idx < IW'(len_q)) begin
               frame[i*SEG_W +: SEG_W] = msg_buf[idx[AW-1:0]];
            end
         end
      end
   end

   // Output register stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         display_p1 <= {NUM_DIGITS{BLANK}};
      end else begin
         display_p1 <= frame;
      end
   end

   assign bus.display_out = display_p1;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.window_pos  = window_pos_q;

endmodule
